flash_cmd_seq: RTL and testbench

Sequences one SPI flash transaction per software command: opcode, optional address, dummy bytes, write payload, then read filler.
- Frames the transaction as a byte stream to the QSPI stream engine.
- Collects the full-duplex response stream and stores only the read-phase bytes into a response buffer.
- Sits between mem_regfile control registers and the flash AXI-stream ports in system2, on axi_aclk.
- Gives software (over PCIe) flash ID, read and program access without a soft CPU.

---
 rtl/flash_cmd_seq.sv | 219 +++++++++++++++++++++
 tb/tb_flash_cmd_seq.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_cmd_seq.sv
// flash_cmd_seq: frames one SPI flash transaction per software command as a
// byte stream to the QSPI stream engine (opcode, address, dummy, write
// payload, read filler) and captures the read-phase response bytes.
//
// Stream handshakes (cmd_* out, rsp_* in): a byte moves on a cycle where
// tvalid and tready are both high at the rising clock edge; once tvalid is
// raised, tvalid/tdata/tlast stay unchanged until that handshake happens.
module flash_cmd_seq #(
   parameter int ADDR_BYTES  = 3,
   parameter int LEN_W       = 9,
   parameter int TIMEOUT_CYC = 1048576
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [7:0]       opcode,
   input  logic             addr_en,
   input  logic [31:0]      addr,
   input  logic [3:0]       dummy,
   input  logic [LEN_W-1:0] wr_len,
   input  logic [LEN_W-1:0] rd_len,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [LEN_W-1:0] rx_count,
   output logic [LEN_W-1:0] wbuf_addr,
   input  logic [7:0]       wbuf_data,
   output logic             rbuf_we,
   output logic [LEN_W-1:0] rbuf_addr,
   output logic [7:0]       rbuf_data,
   output logic [7:0]       cmd_tdata,
   output logic             cmd_tvalid,
   output logic             cmd_tlast,
   input  logic             cmd_tready,
   input  logic [7:0]       rsp_tdata,
   input  logic             rsp_tvalid,
   input  logic             rsp_tlast,
   output logic             rsp_tready,
   output logic [2:0]       tx_state_dbg
);

   // Frame counters need room for 1 + 4 + 15 + 2 * 2^(LEN_W-1) bytes.
   localparam int CNT_W = LEN_W + 2;
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
   localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);
   localparam logic [TMO_W-1:0] ONE_T = TMO_W'(1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      OPC    = 3'd1,
      ADDR   = 3'd2,
      DUMMY  = 3'd3,
      WDATA  = 3'd4,
      RFILL  = 3'd5,
      TXDONE = 3'd6
   } tx_state_t;

   tx_state_t state, state_d, nxt_phase;
   tx_state_t after_op, after_ad, after_dm, after_wd;

   // Command fields latched on an accepted start
   logic [7:0]       opc_q;
   logic             addr_en_q;
   logic [31:0]      addr_sh;
   logic [3:0]       dummy_q;
   logic [LEN_W-1:0] wr_len_q, rd_len_q;
   logic [CNT_W-1:0] n_q, h_q, n_d, h_d;

   logic [CNT_W-1:0] rsp_cnt;
   logic [LEN_W-1:0] ph_left, ph_load, wcnt;
   logic [TMO_W-1:0] tmo_cnt;

   logic start_acc, cmd_hs, rsp_hs, tx_adv, tx_fin, rsp_is_last;
   logic finish_ok, frame_err, timeout, end_txn;

   assign h_d = ONE_C + (addr_en ? CNT_W'(ADDR_BYTES) : '0) + CNT_W'(dummy)
                + CNT_W'(wr_len);
   assign n_d = h_d + CNT_W'(rd_len);

   assign start_acc   = start && !busy;
   assign cmd_hs      = cmd_tvalid && cmd_tready;
   assign rsp_hs      = rsp_tvalid && rsp_tready;
   assign tx_adv      = cmd_hs && (ph_left == '0);
   // TX side is finished once the last command byte has been accepted
   assign tx_fin      = (state == TXDONE) || (cmd_hs && cmd_tlast);
   assign rsp_is_last = (rsp_cnt == n_q - ONE_C);
   assign finish_ok   = rsp_hs && rsp_is_last && rsp_tlast && tx_fin;
   assign frame_err   = rsp_hs && (rsp_is_last ? !(rsp_tlast && tx_fin) : rsp_tlast);
   assign timeout     = busy && !cmd_hs && !rsp_hs && (tmo_cnt == TMO_LAST);
   assign end_txn     = finish_ok || frame_err || timeout;

   // Response bytes past the header are the read data
   assign rbuf_we      = rsp_hs && (rsp_cnt >= h_q);
   assign rbuf_addr    = rx_count;
   assign rbuf_data    = rbuf_we ? rsp_tdata : 8'h00;
   assign rsp_tready   = busy;
   assign tx_state_dbg = state;

   // The write buffer address runs one byte ahead on each accepted payload
   // byte; it sits at 0 before WDATA so byte 0 is ready on entry.
   assign wbuf_addr = (state == WDATA && cmd_hs) ? wcnt + ONE_L : wcnt;

   // Next non-empty phase after each TX phase, and its byte count minus one
   always_comb begin
      nxt_phase = TXDONE;
      ph_load   = '0;
      after_wd  = (rd_len_q != '0) ? RFILL : TXDONE;
      after_dm  = (wr_len_q != '0) ? WDATA : after_wd;
      after_ad  = (dummy_q != '0) ? DUMMY : after_dm;
      after_op  = addr_en_q ? ADDR : after_ad;
      case (state)
         OPC:     nxt_phase = after_op;
         ADDR:    nxt_phase = after_ad;
         DUMMY:   nxt_phase = after_dm;
         WDATA:   nxt_phase = after_wd;
         default: nxt_phase = TXDONE;
      endcase
      case (nxt_phase)
         ADDR:    ph_load = LEN_W'(ADDR_BYTES - 1);
         DUMMY:   ph_load = LEN_W'(dummy_q) - ONE_L;
         WDATA:   ph_load = wr_len_q - ONE_L;
         RFILL:   ph_load = rd_len_q - ONE_L;
         default: ph_load = '0;
      endcase
   end

   // Command byte presented in each TX state
   always_comb begin
      cmd_tvalid = 1'b0;
      cmd_tdata  = 8'h00;
      case (state)
         OPC:          begin cmd_tvalid = 1'b1; cmd_tdata = opc_q;          end
         ADDR:         begin cmd_tvalid = 1'b1; cmd_tdata = addr_sh[31:24]; end
         DUMMY, RFILL: cmd_tvalid = 1'b1;
         WDATA:        begin cmd_tvalid = 1'b1; cmd_tdata = wbuf_data;      end
         default:      ;
      endcase
      cmd_tlast = cmd_tvalid && (ph_left == '0) && (nxt_phase == TXDONE);
   end

   // TX next state: completion/abort wins, then start, then phase advance
   always_comb begin
      state_d = state;
      if (end_txn)
         state_d = IDLE;
      else if (start_acc)
         state_d = OPC;
      else if (tx_adv)
         state_d = nxt_phase;
   end

   // TX state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_d;
   end

   // Command latch, byte counters, timeout and status flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         opc_q     <= '0;
         addr_en_q <= 1'b0;
         addr_sh   <= '0;
         dummy_q   <= '0;
         wr_len_q  <= '0;
         rd_len_q  <= '0;
         n_q       <= '0;
         h_q       <= '0;
         rsp_cnt   <= '0;
         rx_count  <= '0;
         wcnt      <= '0;
         ph_left   <= '0;
         tmo_cnt   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else if (start_acc) begin
         opc_q     <= opcode;
         addr_en_q <= addr_en;
         addr_sh   <= addr << (8 * (4 - ADDR_BYTES));
         dummy_q   <= dummy;
         wr_len_q  <= wr_len;
         rd_len_q  <= rd_len;
         n_q       <= n_d;
         h_q       <= h_d;
         rsp_cnt   <= '0;
         rx_count  <= '0;
         wcnt      <= '0;
         ph_left   <= '0;
         tmo_cnt   <= '0;
         busy      <= 1'b1;
         done      <= 1'b0;
         error     <= 1'b0;
      end else if (busy) begin
         if (cmd_hs) begin
            if (state == ADDR)
               addr_sh <= addr_sh << 8;
            if (state == WDATA)
               wcnt <= wcnt + ONE_L;
            ph_left <= (ph_left == '0) ? ph_load : ph_left - ONE_L;
         end
         if (rsp_hs)
            rsp_cnt <= rsp_cnt + ONE_C;
         if (rbuf_we)
            rx_count <= rx_count + ONE_L;
         tmo_cnt <= (cmd_hs || rsp_hs) ? '0 : tmo_cnt + ONE_T;
         if (end_txn) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            error <= frame_err || timeout;
         end
      end
   end

endmodule

// File: tb/tb_flash_cmd_seq.sv
// tb_flash_cmd_seq: directed and randomized flash transactions against a
// byte-list model of the frame, with a stream-engine model that echoes one
// response byte per accepted command byte.
module tb_flash_cmd_seq;

   localparam int AB  = 3;
   localparam int LW  = 9;
   localparam int TMO = 64;

   // ---------------- clock / reset / DUT ----------------
   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [7:0]    opcode;
   logic          addr_en;
   logic [31:0]   addr;
   logic [3:0]    dummy;
   logic [LW-1:0] wr_len, rd_len;
   logic          busy, done, error;
   logic [LW-1:0] rx_count, wbuf_addr, rbuf_addr;
   logic [7:0]    wbuf_data, rbuf_data;
   logic          rbuf_we;
   logic [7:0]    cmd_tdata;
   logic          cmd_tvalid, cmd_tlast, cmd_tready;
   logic [7:0]    rsp_tdata;
   logic          rsp_tvalid, rsp_tlast, rsp_tready;
   logic [2:0]    tx_state_dbg;

   always #5 clk = ~clk;

   flash_cmd_seq #(.ADDR_BYTES(AB), .LEN_W(LW), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .reset(reset), .start(start), .opcode(opcode),
      .addr_en(addr_en), .addr(addr), .dummy(dummy), .wr_len(wr_len),
      .rd_len(rd_len), .busy(busy), .done(done), .error(error),
      .rx_count(rx_count), .wbuf_addr(wbuf_addr), .wbuf_data(wbuf_data),
      .rbuf_we(rbuf_we), .rbuf_addr(rbuf_addr), .rbuf_data(rbuf_data),
      .cmd_tdata(cmd_tdata), .cmd_tvalid(cmd_tvalid), .cmd_tlast(cmd_tlast),
      .cmd_tready(cmd_tready), .rsp_tdata(rsp_tdata), .rsp_tvalid(rsp_tvalid),
      .rsp_tlast(rsp_tlast), .rsp_tready(rsp_tready),
      .tx_state_dbg(tx_state_dbg)
   );

   // Write buffer: synchronous RAM, data one cycle after address
   logic [7:0] wmem [0:511];
   always @(posedge clk) wbuf_data <= wmem[wbuf_addr];

   // ---------------- scoreboard state ----------------
   int tests_run    = 0;
   int tests_failed = 0;

   logic [7:0] exp_q[$];     // expected command bytes, in order
   logic [7:0] rsp_src[$];   // bytes the engine model returns
   int         rmem [0:511]; // captured response-buffer writes

   // transaction config
   logic [7:0]  t_op;
   logic        t_ae;
   logic [31:0] t_addr;
   logic [3:0]  t_dummy;
   int t_wr, t_rd, tready_mode, tlast_at, busy_start_at, budget;
   logic rvalid_rand;
   // transaction observations
   int n_cmd, n_rsp, n_wr, last_rsp_cyc, end_cyc, stall_cnt, h_exp, n_exp;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic new_txn(input logic [7:0] op, input logic ae, input logic [31:0] a,
                          input logic [3:0] dm, input int wl, input int rl);
      t_op = op; t_ae = ae; t_addr = a; t_dummy = dm; t_wr = wl; t_rd = rl;
      tready_mode = 0; rvalid_rand = 1'b0; tlast_at = 0; busy_start_at = -1;
      budget = 400;
      rsp_src.delete();
   endtask

   task automatic run_txn;
      logic       pend;
      logic [7:0] pend_data, exp_b;
      int         cyc;
      // Reference frame: opcode, address MSB-first, zeros, payload, zeros
      exp_q.delete();
      exp_q.push_back(t_op);
      if (t_ae)
         for (int b = AB - 1; b >= 0; b--) exp_q.push_back(8'(t_addr >> (8 * b)));
      for (int i = 0; i < int'(t_dummy); i++) exp_q.push_back(8'h00);
      for (int i = 0; i < t_wr; i++) exp_q.push_back(wmem[i]);
      h_exp = exp_q.size();
      for (int i = 0; i < t_rd; i++) exp_q.push_back(8'h00);
      n_exp = exp_q.size();
      if (tlast_at == 0) tlast_at = n_exp;
      while (rsp_src.size() < n_exp) rsp_src.push_back(8'($urandom_range(0, 255)));
      for (int i = 0; i < 512; i++) rmem[i] = -1;

      @(negedge clk);
      opcode = t_op; addr_en = t_ae; addr = t_addr; dummy = t_dummy;
      wr_len = LW'(t_wr); rd_len = LW'(t_rd);
      start = 1'b1; cmd_tready = 1'b0; rsp_tvalid = 1'b0; rsp_tlast = 1'b0;
      @(negedge clk);
      start = 1'b0;
      // inputs are latched at start; scramble them for the rest of the frame
      opcode = 8'($urandom); addr_en = 1'($urandom); addr = $urandom;
      dummy = 4'($urandom); wr_len = LW'($urandom); rd_len = LW'($urandom);
      n_cmd = 0; n_rsp = 0; n_wr = 0; last_rsp_cyc = -100; stall_cnt = 0;
      pend = 1'b0; pend_data = 8'h00; cyc = 0;
      forever begin
         case (tready_mode)
            0:       cmd_tready = 1'b1;
            1:       cmd_tready = (cyc % 2 == 0);
            2:       cmd_tready = ($urandom_range(0, 1) == 1);
            default: cmd_tready = 1'b0;
         endcase
         rsp_tvalid = (n_rsp < n_cmd) && (!rvalid_rand || $urandom_range(0, 1) == 1);
         rsp_tdata  = (n_rsp < rsp_src.size()) ? rsp_src[n_rsp] : 8'h00;
         rsp_tlast  = rsp_tvalid && (n_rsp + 1 == tlast_at);
         start      = (cyc == busy_start_at);
         #1;
         if (!busy) break;
         if (cyc == 0) begin
            check("clr_done", done, 0);
            check("clr_error", error, 0);
            check("clr_rx_count", rx_count, 0);
         end
         if (pend) begin
            check("hold_tvalid", cmd_tvalid, 1);
            check("hold_tdata", cmd_tdata, pend_data);
         end
         if (cmd_tready && !cmd_tvalid && exp_q.size() > 0) stall_cnt++;
         if (cmd_tvalid && cmd_tready) begin
            if (exp_q.size() == 0)
               check("extra_cmd_byte", n_cmd + 1, n_exp);
            else begin
               exp_b = exp_q.pop_front();
               check("cmd_byte", cmd_tdata, exp_b);
               check("cmd_tlast", cmd_tlast, exp_q.size() == 0);
            end
            n_cmd++;
         end
         pend      = cmd_tvalid && !cmd_tready;
         pend_data = cmd_tdata;
         if (rsp_tvalid && rsp_tready) begin
            n_rsp++;
            last_rsp_cyc = cyc;
         end
         if (rbuf_we) begin
            rmem[rbuf_addr] = rbuf_data;
            n_wr++;
         end
         cyc++;
         if (cyc > budget) begin
            check("cycle_budget", cyc, budget);
            break;
         end
         @(negedge clk);
      end
      start = 1'b0; cmd_tready = 1'b0; rsp_tvalid = 1'b0; rsp_tlast = 1'b0;
      end_cyc = cyc;
   endtask

   task automatic check_normal;
      check("unsent_cmd_bytes", exp_q.size(), 0);
      check("done", done, 1);
      check("error", error, 0);
      check("busy", busy, 0);
      check("rx_count", rx_count, t_rd);
      check("rbuf_writes", n_wr, t_rd);
      for (int i = 0; i < t_rd; i++) check("rbuf_data", rmem[i], rsp_src[h_exp + i]);
      check("done_latency", end_cyc, last_rsp_cyc + 1);
      check("idle_outputs", {cmd_tvalid, rsp_tready, rbuf_we}, 0);
      if (tready_mode == 0) check("wdata_bubbles_le1", stall_cnt <= 1, 1);
   endtask

   task automatic check_all_zero;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_rx_count", rx_count, 0);
      check("rst_wbuf_addr", wbuf_addr, 0);
      check("rst_rbuf", {rbuf_we, rbuf_addr, rbuf_data}, 0);
      check("rst_cmd", {cmd_tvalid, cmd_tlast, cmd_tdata}, 0);
      check("rst_rsp_tready", rsp_tready, 0);
      check("rst_state", tx_state_dbg, 0);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      reset = 1'b1; start = 1'b0; opcode = '0; addr_en = 1'b0; addr = '0;
      dummy = '0; wr_len = '0; rd_len = '0; cmd_tready = 1'b0;
      rsp_tdata = '0; rsp_tvalid = 1'b0; rsp_tlast = 1'b0;
      for (int i = 0; i < 512; i++) wmem[i] = 8'($urandom_range(0, 255));
      repeat (3) @(negedge clk);
      check_all_zero();
      reset = 1'b0;
      @(negedge clk);
      check_all_zero();

      // Read ID
      new_txn(8'h9F, 1'b0, 32'h0, 4'd0, 0, 3);
      rsp_src = '{8'hFF, 8'hEF, 8'h40, 8'h18};
      run_txn();
      check_normal();
      check("rid_rbuf0", rmem[0], 32'hEF);
      check("rid_rbuf2", rmem[2], 32'h18);

      // Fast read with address and one dummy byte
      new_txn(8'h0B, 1'b1, 32'h00123456, 4'd1, 0, 4);
      run_txn();
      check_normal();
      check("fr_frame_len", n_cmd, 9);

      // Page program with a stalling engine
      wmem[0] = 8'hA1; wmem[1] = 8'hB2; wmem[2] = 8'hC3; wmem[3] = 8'hD4;
      new_txn(8'h02, 1'b1, 32'h00000100, 4'd0, 4, 0);
      tready_mode = 1;
      run_txn();
      check_normal();
      check("pp_frame_len", n_cmd, 8);

      // Framing: engine ends the frame one byte early
      new_txn(8'h9F, 1'b0, 32'h0, 4'd0, 0, 2);
      tlast_at = 2;
      run_txn();
      check("frm_error", error, 1);
      check("frm_done", done, 1);
      check("frm_busy", busy, 0);
      check("frm_latency", end_cyc, last_rsp_cyc + 1);
      check("frm_rx_count", rx_count, 1);

      // Timeout: engine never accepts
      new_txn(8'h9F, 1'b0, 32'h0, 4'd0, 0, 3);
      tready_mode = 3;
      budget = 200;
      run_txn();
      check("tmo_cycles", end_cyc, TMO);
      check("tmo_error", error, 1);
      check("tmo_done", done, 1);
      check("tmo_busy", busy, 0);
      check("tmo_streams_off", {cmd_tvalid, rsp_tready}, 0);
      // new start clears the error and completes normally
      new_txn(8'h9F, 1'b0, 32'h0, 4'd0, 0, 3);
      run_txn();
      check_normal();

      // start pulse while busy leaves the frame unchanged
      new_txn(8'h0B, 1'b1, 32'h00ABCDEF, 4'd2, 2, 3);
      busy_start_at = 2;
      run_txn();
      check_normal();

      // reset in the middle of the address phase
      @(negedge clk);
      opcode = 8'h0B; addr_en = 1'b1; addr = 32'h00123456; dummy = 4'd1;
      wr_len = '0; rd_len = LW'(4); start = 1'b1; cmd_tready = 1'b0;
      @(negedge clk);
      start = 1'b0; cmd_tready = 1'b1;
      @(negedge clk);
      cmd_tready = 1'b0;
      #1;
      check("mid_addr_byte", {cmd_tvalid, cmd_tdata}, {1'b1, 8'h12});
      reset = 1'b1;
      #1;
      check_all_zero();
      @(negedge clk);
      reset = 1'b0;
      new_txn(8'h9F, 1'b0, 32'h0, 4'd0, 0, 3);
      rsp_src = '{8'h00, 8'hC2, 8'h20, 8'h17};
      run_txn();
      check_normal();

      // Boundary: maximum payload and read length
      new_txn(8'h5A, 1'b1, 32'hFFEEDDCC, 4'd15, 256, 256);
      budget = 1500;
      run_txn();
      check_normal();
      check("max_frame_len", n_cmd, 1 + AB + 15 + 512);

      // Randomized commands
      for (int k = 0; k < 16; k++) begin
         new_txn(8'($urandom), 1'($urandom), $urandom, 4'($urandom_range(0, 3)),
                 int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
         tready_mode = ($urandom_range(0, 1) == 1) ? 2 : 0;
         rvalid_rand = 1'($urandom);
         run_txn();
         check_normal();
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
